// File: rtl/serial_bit_tx_if.sv
// Handshake and serial-output bundle for serial_bit_tx.
// The slave side is the transmitter and the master side is the word producer or the bench.
interface serial_bit_tx_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             dout_bit;
  logic             dout_valid;
  logic             frame_done;
  logic             busy;
  logic [CW-1:0]    eq_pairs;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, dout_bit, dout_valid, frame_done, busy, eq_pairs
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, dout_bit, dout_valid, frame_done, busy, eq_pairs
  );
endinterface

// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter: shifts out one bit per clock and reports
// how many adjacent bit pairs in the current word are equal.
module serial_bit_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic        IDLE_BIT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  serial_bit_tx_if.slave   bus
);

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam int unsigned    GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0]  GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_dout_bit;
  logic [CW-1:0]    r_eq_pairs;

  logic             w_last;
  logic             w_gap_done;
  logic             w_tx_ready;
  logic             w_accept;

  function automatic logic [CW-1:0] count_eq(input logic [WIDTH-1:0] d);
    logic [CW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < WIDTH - 1; i++) begin
      if (d[i] == d[i+1]) n = n + CW'(1);
    end
    return n;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_last      = (r_state == S_SHIFT) && (r_cnt == CNT_LAST);
    w_gap_done  = (r_gap_cnt == GAP_LAST);
    // Re-arm on the last bit only when no gap follows, so words stream without a bubble.
    w_tx_ready  = (r_state == S_IDLE) || (w_last && (GAP_CYCLES == 0));
    w_accept    = bus.tx_valid && w_tx_ready;

    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_last) begin
          if (GAP_CYCLES > 0)  w_state_nxt = S_GAP;
          else if (w_accept)   w_state_nxt = S_SHIFT;
          else                 w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (w_gap_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_gap_cnt  <= '0;
      r_dout_bit <= IDLE_BIT;
      r_eq_pairs <= '0;
    end else begin
      r_state <= w_state_nxt;

      // The first bit goes straight to the output register; the shift register keeps the rest.
      if (w_accept) begin
        r_cnt      <= '0;
        r_eq_pairs <= count_eq(bus.tx_data);
        if (MSB_FIRST != 0) begin
          r_dout_bit <= bus.tx_data[WIDTH-1];
          r_shreg    <= bus.tx_data << 1;
        end else begin
          r_dout_bit <= bus.tx_data[0];
          r_shreg    <= bus.tx_data >> 1;
        end
      end else if ((r_state == S_SHIFT) && !w_last) begin
        r_cnt <= r_cnt + CW'(1);
        if (MSB_FIRST != 0) begin
          r_dout_bit <= r_shreg[WIDTH-1];
          r_shreg    <= r_shreg << 1;
        end else begin
          r_dout_bit <= r_shreg[0];
          r_shreg    <= r_shreg >> 1;
        end
      end else if (w_state_nxt != S_SHIFT) begin
        r_dout_bit <= IDLE_BIT;
      end

      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + GW'(1);
      else                  r_gap_cnt <= '0;
    end
  end

  assign bus.tx_ready   = w_tx_ready;
  assign bus.dout_bit   = r_dout_bit;
  assign bus.dout_valid = (r_state == S_SHIFT);
  assign bus.frame_done = w_last;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.eq_pairs   = r_eq_pairs;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx: three configurations (default, two-cycle gap, LSB first)
// driven with directed and random words and checked against a word-level model.
module tb_serial_bit_tx;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  int         sel;
  int         total;
  int         bad;

  logic       o_ready, o_bit, o_valid, o_fd, o_busy;
  logic [2:0] o_eq;

  serial_bit_tx_if #(.WIDTH(8)) if0 ();
  serial_bit_tx_if #(.WIDTH(8)) if1 ();
  serial_bit_tx_if #(.WIDTH(8)) if2 ();

  assign if0.tx_data  = tx_data;
  assign if1.tx_data  = tx_data;
  assign if2.tx_data  = tx_data;
  assign if0.tx_valid = tx_valid && (sel == 0);
  assign if1.tx_valid = tx_valid && (sel == 1);
  assign if2.tx_valid = tx_valid && (sel == 2);

  serial_bit_tx #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0), .IDLE_BIT(1'b0))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  serial_bit_tx #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(2), .IDLE_BIT(1'b0))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  serial_bit_tx #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(0), .IDLE_BIT(1'b0))
    u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  always_comb begin
    case (sel)
      1: begin
        o_ready = if1.tx_ready; o_bit = if1.dout_bit; o_valid = if1.dout_valid;
        o_fd = if1.frame_done; o_busy = if1.busy; o_eq = if1.eq_pairs;
      end
      2: begin
        o_ready = if2.tx_ready; o_bit = if2.dout_bit; o_valid = if2.dout_valid;
        o_fd = if2.frame_done; o_busy = if2.busy; o_eq = if2.eq_pairs;
      end
      default: begin
        o_ready = if0.tx_ready; o_bit = if0.dout_bit; o_valid = if0.dout_valid;
        o_fd = if0.frame_done; o_busy = if0.busy; o_eq = if0.eq_pairs;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-level model: bit order by index, equal pairs via XOR of the word with itself shifted.
  function automatic logic exp_bit(input logic [7:0] w, input int k, input bit msb);
    return msb ? w[7-k] : w[k];
  endfunction

  function automatic int exp_eq(input logic [7:0] w);
    logic [7:0] same;
    same = ~(w ^ (w >> 1)) & 8'h7F;
    return $countones(same);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s sel=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_stream(input logic [7:0] words[$]);
    int          gap;
    bit          msb;
    int unsigned wait_n;
    gap = (sel == 1) ? 2 : 0;
    msb = (sel != 2);
    tx_data  = words[0];
    tx_valid = 1'b1;
    wait_n   = 0;
    while (!o_ready && wait_n < 20) begin
      tick();
      wait_n++;
    end
    chk("ready_before_accept", 32'(o_ready), 1);
    tick();
    foreach (words[n]) begin
      for (int k = 0; k < 8; k++) begin
        chk("dout_valid", 32'(o_valid), 1);
        chk("dout_bit",   32'(o_bit),   32'(exp_bit(words[n], k, msb)));
        chk("frame_done", 32'(o_fd),    32'(k == 7));
        chk("busy",       32'(o_busy),  1);
        chk("tx_ready",   32'(o_ready), 32'((k == 7) && (gap == 0)));
        chk("eq_pairs",   32'(o_eq),    32'(exp_eq(words[n])));
        if (k < 7)                       tx_data = 8'($urandom);
        else if (n + 1 < words.size())   tx_data = words[n+1];
        else                             tx_valid = 1'b0;
        tick();
      end
      if (gap > 0) begin
        for (int g = 0; g < gap; g++) begin
          chk("gap_valid", 32'(o_valid), 0);
          chk("gap_ready", 32'(o_ready), 0);
          chk("gap_busy",  32'(o_busy),  1);
          chk("gap_bit",   32'(o_bit),   0);
          chk("gap_fd",    32'(o_fd),    0);
          tick();
        end
        chk("post_gap_ready", 32'(o_ready), 1);
        chk("post_gap_busy",  32'(o_busy),  0);
        chk("post_gap_valid", 32'(o_valid), 0);
        if (n + 1 < words.size()) tick();
      end
    end
    if (gap == 0) begin
      chk("end_ready", 32'(o_ready), 1);
      chk("end_valid", 32'(o_valid), 0);
      chk("end_busy",  32'(o_busy),  0);
      chk("end_bit",   32'(o_bit),   0);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic       fd_seen;
    total    = 0;
    bad      = 0;
    sel      = 0;
    tx_data  = '0;
    tx_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) tick();

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      chk("rst_ready", 32'(o_ready), 1);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_bit",   32'(o_bit),   0);
      chk("rst_busy",  32'(o_busy),  0);
      chk("rst_fd",    32'(o_fd),    0);
      chk("rst_eq",    32'(o_eq),    0);
    end
    reset = 1'b1;
    sel   = 0;
    tick();

    q = '{8'b0011_0110};
    send_stream(q);
    chk("eq_0x36", 32'(o_eq), 3);

    q = '{8'hFF, 8'h00};
    send_stream(q);

    sel = 1;
    #0;
    q = '{8'hC3, 8'h5A};
    send_stream(q);

    sel = 2;
    #0;
    q = '{8'h01};
    send_stream(q);
    chk("eq_0x01", 32'(o_eq), 6);

    // Abort mid-frame after the third bit of 0xA5.
    sel      = 0;
    #0;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("abort_bit", 32'(o_bit), 32'(exp_bit(8'hA5, k, 1'b1)));
      if (k < 2) tick();
    end
    reset = 1'b0;
    tick();
    chk("abort_valid", 32'(o_valid), 0);
    chk("abort_busy",  32'(o_busy),  0);
    chk("abort_ready", 32'(o_ready), 1);
    chk("abort_fd",    32'(o_fd),    0);
    chk("abort_eq",    32'(o_eq),    0);
    reset   = 1'b1;
    fd_seen = 1'b0;
    repeat (12) begin
      tick();
      fd_seen = fd_seen | o_fd;
    end
    chk("abort_no_fd", 32'(fd_seen), 0);

    // Reset wins over an accept in the same cycle.
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    reset    = 1'b0;
    tick();
    tx_valid = 1'b0;
    reset    = 1'b1;
    chk("rst_prio_busy",  32'(o_busy),  0);
    chk("rst_prio_valid", 32'(o_valid), 0);
    tick();
    chk("rst_prio_idle",  32'(o_busy),  0);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      repeat (4) begin
        q = {};
        repeat ($urandom_range(1, 3)) q.push_back(8'($urandom));
        send_stream(q);
        repeat ($urandom_range(0, 2)) tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
